// File: rtl/axum_arb_pkg.sv
// Shared types and the round-robin pick helper for the host arbiter.
//   host_id_t : host index, sized for the largest supported host count
//   rr_pick   : first requesting host at or after ptr, wrapping at n
package axum_arb_pkg;

  localparam int unsigned MaxHosts    = 16;
  localparam int unsigned HostIdWidth = $clog2(MaxHosts);

  typedef logic [HostIdWidth-1:0] host_id_t;

  // Returns ptr unchanged when nothing requests; callers gate on |req.
  function automatic host_id_t rr_pick(input logic [MaxHosts-1:0] req,
                                       input host_id_t            ptr,
                                       input int unsigned         n);
    host_id_t    pick;
    host_id_t    idx_id;
    logic        found;
    int unsigned idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxHosts; k++) begin
      idx    = (32'(ptr) + k) % n;
      idx_id = HostIdWidth'(idx);
      if ((k < n) && !found && req[idx_id]) begin
        pick  = idx_id;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axum_id_fifo.sv
// In-order FIFO of granted host IDs; head readable combinationally.
//   push/wdata : enqueue (caller guarantees !full)
//   pop        : dequeue head (caller guarantees !empty)
//   rdata      : current head
//   full/empty : occupancy flags
module axum_id_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Pointer advance with explicit wrap so non-power-of-2 depths stay correct.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/axum_host_arb.sv
// Round-robin arbiter sharing one req/gnt/rvalid bus host port among NrHosts requesters.
//   host_* : per-host request side (gnt/rvalid/err routed, rdata broadcast)
//   dev_*  : shared bus host port (request fields muxed, zero when idle)
//   proto_err_o : sticky, rvalid arrived with nothing outstanding
module axum_host_arb
  import axum_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NrHosts-1:0]      host_req_i,
  output logic [NrHosts-1:0]      host_gnt_o,
  input  logic [AddressWidth-1:0] host_addr_i  [NrHosts],
  input  logic [NrHosts-1:0]      host_we_i,
  input  logic [3:0]              host_be_i    [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]      host_rvalid_o,
  output logic [DataWidth-1:0]    host_rdata_o [NrHosts],
  output logic [NrHosts-1:0]      host_err_o,
  output logic                    dev_req_o,
  input  logic                    dev_gnt_i,
  output logic [AddressWidth-1:0] dev_addr_o,
  output logic                    dev_we_o,
  output logic [3:0]              dev_be_o,
  output logic [DataWidth-1:0]    dev_wdata_o,
  input  logic                    dev_rvalid_i,
  input  logic [DataWidth-1:0]    dev_rdata_i,
  input  logic                    dev_err_i,
  output logic                    proto_err_o
);

  localparam int unsigned IdW = $clog2(NrHosts);

  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic           lock_q, lock_d;
  logic [IdW-1:0] lock_id_q, lock_id_d;
  logic           proto_err_q, proto_err_d;

  logic [IdW-1:0] pick_c;
  logic [IdW-1:0] sel_c;
  logic           locked_c;
  logic           hs_c;
  logic           pop_c;
  logic           fifo_full, fifo_empty;
  logic [IdW-1:0] head_id;

  // Lock only survives while the locked host keeps requesting.
  assign pick_c   = IdW'(rr_pick(MaxHosts'(host_req_i), HostIdWidth'(rr_ptr_q), NrHosts));
  assign locked_c = lock_q & host_req_i[lock_id_q];
  assign sel_c    = locked_c ? lock_id_q : pick_c;
  assign hs_c     = dev_req_o & dev_gnt_i;
  assign pop_c    = dev_rvalid_i & ~fifo_empty;

  axum_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (hs_c),
    .pop   (pop_c),
    .wdata (sel_c),
    .rdata (head_id),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Request mux and grant; full blocks requests even when a pop lands this cycle.
  always_comb begin
    dev_req_o   = 1'b0;
    dev_addr_o  = '0;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_wdata_o = '0;
    host_gnt_o  = '0;
    dev_req_o   = (|host_req_i) & ~fifo_full;
    if (dev_req_o) begin
      dev_addr_o  = host_addr_i[sel_c];
      dev_we_o    = host_we_i[sel_c];
      dev_be_o    = host_be_i[sel_c];
      dev_wdata_o = host_wdata_i[sel_c];
    end
    for (int i = 0; i < int'(NrHosts); i++) begin
      host_gnt_o[i] = hs_c & (sel_c == IdW'(i));
    end
  end

  // Response demux to the FIFO head's owner; data is broadcast.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int i = 0; i < int'(NrHosts); i++) begin
      host_rdata_o[i]  = dev_rdata_i;
      host_rvalid_o[i] = pop_c & (head_id == IdW'(i));
      host_err_o[i]    = pop_c & (head_id == IdW'(i)) & dev_err_i;
    end
  end

  // Pointer, lock and sticky error next-state.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = 1'b0;
    lock_id_d   = lock_id_q;
    proto_err_d = proto_err_q | (dev_rvalid_i & fifo_empty);
    if (hs_c) begin
      rr_ptr_d = (sel_c == IdW'(NrHosts - 1)) ? '0 : sel_c + IdW'(1);
    end else if (dev_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel_c;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err_o = proto_err_q;

endmodule
